// File: rtl/lcd_ks0108_pkg.sv
// Shared definitions for the KS0108 dual-controller LCD sequencer:
// command opcodes, main FSM states and bus-cycle phases.
package lcd_ks0108_pkg;

   localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
   localparam logic [7:0] CMD_START_LINE = 8'hC0;
   localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
   localparam logic [7:0] CMD_SET_Y      = 8'h40;

   typedef enum logic [2:0] {
      ST_RST_HOLD = 3'd0,
      ST_INIT     = 3'd1,
      ST_IDLE     = 3'd2,
      ST_DECIDE   = 3'd3,
      ST_SET_PAGE = 3'd4,
      ST_SET_COL  = 3'd5,
      ST_WRITE    = 3'd6
   } main_state_e;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_SETUP = 2'd1,
      PH_HIGH  = 2'd2,
      PH_HOLD  = 2'd3
   } bus_phase_e;

   // Init commands in issue order, broadcast to both controllers.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_DISP_ON;
         2'd1:    return CMD_START_LINE;
         2'd2:    return CMD_SET_PAGE;
         default: return CMD_SET_Y;
      endcase
   endfunction

endpackage

// File: rtl/lcd_ks0108_seq_bus_cycle.sv
// One LCD write cycle: SETUP (EN_HALF clks), HIGH (EN_HALF clks), HOLD (1 clk).
// A start seen while idle or in HOLD launches the next cycle with no gap.
module lcd_bus_cycle
   import lcd_ks0108_pkg::*;
#(
   parameter int EN_HALF = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       di,
   input  logic       cs1,
   input  logic       cs2,
   output logic [7:0] lcd_data,
   output logic       lcd_en,
   output logic       lcd_di,
   output logic       lcd_cs1,
   output logic       lcd_cs2,
   output logic       done
);

   localparam int CW = (EN_HALF > 1) ? $clog2(EN_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(EN_HALF - 1);

   bus_phase_e    phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_q, en_d;
   logic [7:0]    data_q, data_d;
   logic          di_q, di_d;
   logic          cs1_q, cs1_d;
   logic          cs2_q, cs2_d;

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      data_d  = data_q;
      di_d    = di_q;
      cs1_d   = cs1_q;
      cs2_d   = cs2_q;
      case (phase_q)
         PH_SETUP: begin
            if (cnt_q == CNT_LAST) begin
               phase_d = PH_HIGH;
               en_d    = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PH_HIGH: begin
            if (cnt_q == CNT_LAST) begin
               phase_d = PH_HOLD;
               en_d    = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PH_HOLD: phase_d = PH_IDLE;
         default: phase_d = PH_IDLE;
      endcase
      // Bus fields only ever change here, at SETUP entry.
      if (start && (phase_q == PH_IDLE || phase_q == PH_HOLD)) begin
         phase_d = PH_SETUP;
         cnt_d   = '0;
         en_d    = 1'b0;
         data_d  = data;
         di_d    = di;
         cs1_d   = cs1;
         cs2_d   = cs2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         data_q  <= 8'h00;
         di_q    <= 1'b0;
         cs1_q   <= 1'b0;
         cs2_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         data_q  <= data_d;
         di_q    <= di_d;
         cs1_q   <= cs1_d;
         cs2_q   <= cs2_d;
      end
   end

   assign lcd_data = data_q;
   assign lcd_en   = en_q;
   assign lcd_di   = di_q;
   assign lcd_cs1  = cs1_q;
   assign lcd_cs2  = cs2_q;
   assign done     = (phase_q == PH_HOLD);

endmodule

// File: rtl/lcd_ks0108_seq.sv
// KS0108 128x64 LCD sequencer: power-up/init, then page/column/data writes
// with per-controller address caches so redundant address commands are skipped.
module lcd_ks0108_seq
   import lcd_ks0108_pkg::*;
#(
   parameter int EN_HALF    = 4,
   parameter int RST_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_page,
   input  logic [6:0] req_col,
   input  logic [7:0] req_data,
   output logic       init_done,
   output logic [7:0] LCD_data,
   output logic       LCD_en,
   output logic       LCD_rw,
   output logic       LCD_rstn,
   output logic       LCD_cs1,
   output logic       LCD_cs2,
   output logic       LCD_di
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   main_state_e     state_q, state_d;
   logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [1:0]      init_idx_q, init_idx_d;
   logic [2:0]      page_q, page_d;
   logic [6:0]      col_q, col_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [1:0][2:0] page_c_q, page_c_d;
   logic [1:0][5:0] col_c_q, col_c_d;
   logic [1:0]      valid_q, valid_d;
   logic            ready_q, ready_d;
   logic            init_done_q, init_done_d;
   logic            lcd_rstn_q, lcd_rstn_d;

   logic            start;
   logic [7:0]      cmd_data;
   logic            cmd_di, cmd_cs1, cmd_cs2;
   logic            bus_done;
   logic            sel;
   logic            page_hit, col_hit;

   // sel = 0 addresses the left controller (CS1), 1 the right (CS2).
   assign sel      = col_q[6];
   assign page_hit = valid_q[sel] && (page_c_q[sel] == page_q);
   assign col_hit  = valid_q[sel] && (col_c_q[sel] == col_q[5:0]);

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      init_idx_d  = init_idx_q;
      page_d      = page_q;
      col_d       = col_q;
      wdata_d     = wdata_q;
      page_c_d    = page_c_q;
      col_c_d     = col_c_q;
      valid_d     = valid_q;
      ready_d     = ready_q;
      init_done_d = init_done_q;
      lcd_rstn_d  = lcd_rstn_q;
      start       = 1'b0;
      case (state_q)
         ST_RST_HOLD: begin
            if (rst_cnt_q == RST_LAST) begin
               lcd_rstn_d = 1'b1;
               init_idx_d = 2'd0;
               state_d    = ST_INIT;
               start      = 1'b1;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         ST_INIT: begin
            if (bus_done) begin
               if (init_idx_q == 2'd3) begin
                  page_c_d    = '0;
                  col_c_d     = '0;
                  valid_d     = 2'b11;
                  init_done_d = 1'b1;
                  ready_d     = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  init_idx_d = init_idx_q + 1'b1;
                  start      = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (req_valid) begin
               page_d  = req_page;
               col_d   = req_col;
               wdata_d = req_data;
               ready_d = 1'b0;
               state_d = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            start = 1'b1;
            if (!page_hit)     state_d = ST_SET_PAGE;
            else if (!col_hit) state_d = ST_SET_COL;
            else               state_d = ST_WRITE;
         end
         ST_SET_PAGE: begin
            if (bus_done) begin
               page_c_d[sel] = page_q;
               start         = 1'b1;
               state_d       = col_hit ? ST_WRITE : ST_SET_COL;
            end
         end
         ST_SET_COL: begin
            if (bus_done) begin
               col_c_d[sel] = col_q[5:0];
               start        = 1'b1;
               state_d      = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // The panel auto-increments Y within its own half only.
            if (bus_done) begin
               col_c_d[sel] = col_c_q[sel] + 1'b1;
               ready_d      = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_RST_HOLD;
      endcase

      cmd_data = 8'h00;
      cmd_di   = 1'b0;
      cmd_cs1  = 1'b0;
      cmd_cs2  = 1'b0;
      if (start) begin
         case (state_d)
            ST_INIT: begin
               cmd_data = init_cmd(init_idx_d);
               cmd_cs1  = 1'b1;
               cmd_cs2  = 1'b1;
            end
            ST_SET_PAGE: begin
               cmd_data = CMD_SET_PAGE | {5'b0, page_q};
               cmd_cs1  = ~sel;
               cmd_cs2  = sel;
            end
            ST_SET_COL: begin
               cmd_data = CMD_SET_Y | {2'b0, col_q[5:0]};
               cmd_cs1  = ~sel;
               cmd_cs2  = sel;
            end
            ST_WRITE: begin
               cmd_data = wdata_q;
               cmd_di   = 1'b1;
               cmd_cs1  = ~sel;
               cmd_cs2  = sel;
            end
            default: cmd_data = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST_HOLD;
         rst_cnt_q   <= '0;
         init_idx_q  <= 2'd0;
         page_q      <= 3'd0;
         col_q       <= 7'd0;
         wdata_q     <= 8'h00;
         page_c_q    <= '0;
         col_c_q     <= '0;
         valid_q     <= 2'b00;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
         lcd_rstn_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         init_idx_q  <= init_idx_d;
         page_q      <= page_d;
         col_q       <= col_d;
         wdata_q     <= wdata_d;
         page_c_q    <= page_c_d;
         col_c_q     <= col_c_d;
         valid_q     <= valid_d;
         ready_q     <= ready_d;
         init_done_q <= init_done_d;
         lcd_rstn_q  <= lcd_rstn_d;
      end
   end

   lcd_bus_cycle #(.EN_HALF(EN_HALF)) u_bus (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .data     (cmd_data),
      .di       (cmd_di),
      .cs1      (cmd_cs1),
      .cs2      (cmd_cs2),
      .lcd_data (LCD_data),
      .lcd_en   (LCD_en),
      .lcd_di   (LCD_di),
      .lcd_cs1  (LCD_cs1),
      .lcd_cs2  (LCD_cs2),
      .done     (bus_done)
   );

   assign req_ready = ready_q;
   assign init_done = init_done_q;
   assign LCD_rstn  = lcd_rstn_q;
   assign LCD_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ks0108_seq.sv
// Directed bench for lcd_ks0108_seq with EN_HALF=2, RST_CYCLES=4: init, cached
// writes, column wrap, and asynchronous reset in the middle of an LCD_en pulse.
module tb_lcd_ks0108_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_page = 3'd0;
   logic [6:0] req_col = 7'd0;
   logic [7:0] req_data = 8'h00;
   logic       init_done;
   logic [7:0] LCD_data;
   logic       LCD_en, LCD_rw, LCD_rstn, LCD_cs1, LCD_cs2, LCD_di;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc = 0;
   int c0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_ks0108_seq #(.EN_HALF(2), .RST_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_page  (req_page),
      .req_col   (req_col),
      .req_data  (req_data),
      .init_done (init_done),
      .LCD_data  (LCD_data),
      .LCD_en    (LCD_en),
      .LCD_rw    (LCD_rw),
      .LCD_rstn  (LCD_rstn),
      .LCD_cs1   (LCD_cs1),
      .LCD_cs2   (LCD_cs2),
      .LCD_di    (LCD_di)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for the next LCD_en pulse and check its timing and bus contents.
   task automatic expect_cycle(input string tag, input int rise, input logic [7:0] d,
                               input logic di, input logic cs1, input logic cs2);
      int n = 0;
      while (LCD_en !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_en"}, 32'(LCD_en), 32'd1);
      check({tag, "_rise"}, 32'(cyc), 32'(rise));
      check({tag, "_data"}, 32'(LCD_data), 32'(d));
      check({tag, "_di_cs"}, 32'({LCD_di, LCD_cs1, LCD_cs2}), 32'({di, cs1, cs2}));
      @(negedge clk);
      check({tag, "_high2"}, 32'(LCD_en), 32'd1);
      @(negedge clk);
      check({tag, "_hold"}, 32'({LCD_en, LCD_data, LCD_di, LCD_cs1, LCD_cs2}),
            32'({1'b0, d, di, cs1, cs2}));
   endtask

   task automatic wait_ready(input string tag, input int exp_cyc);
      int n = 0;
      while (req_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_ready_cyc"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_init_done"}, 32'(init_done), 32'd1);
   endtask

   task automatic send_req(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_pre", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_page  = p;
      req_col   = c;
      req_data  = d;
      acc       = cyc + 1;
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_drop", 32'(req_ready), 32'd0);
   endtask

   // Release reset at a negedge and follow the whole power-up sequence.
   task automatic run_init(input string p);
      rst_n = 1'b1;
      c0 = cyc;
      repeat (3) @(negedge clk);
      check({p, "_rstn_low"}, 32'({LCD_rstn, req_ready, init_done}), 32'd0);
      @(negedge clk);
      check({p, "_rstn_high"}, 32'(LCD_rstn), 32'd1);
      expect_cycle({p, "_3f"}, c0 + 6,  8'h3F, 1'b0, 1'b1, 1'b1);
      expect_cycle({p, "_c0"}, c0 + 11, 8'hC0, 1'b0, 1'b1, 1'b1);
      expect_cycle({p, "_b8"}, c0 + 16, 8'hB8, 1'b0, 1'b1, 1'b1);
      expect_cycle({p, "_40"}, c0 + 21, 8'h40, 1'b0, 1'b1, 1'b1);
      wait_ready({p, "_done"}, c0 + 24);
      check({p, "_rw"}, 32'(LCD_rw), 32'd0);
   endtask

   initial begin
      int n;
      @(negedge clk);
      check("reset_vals",
            32'({LCD_rstn, LCD_en, LCD_rw, LCD_di, LCD_cs1, LCD_cs2, LCD_data, req_ready, init_done}),
            32'd0);
      @(negedge clk);
      run_init("init");

      send_req(3'd2, 7'd5, 8'hA5);
      expect_cycle("r1_page", acc + 3,  8'hBA, 1'b0, 1'b1, 1'b0);
      expect_cycle("r1_col",  acc + 8,  8'h45, 1'b0, 1'b1, 1'b0);
      expect_cycle("r1_data", acc + 13, 8'hA5, 1'b1, 1'b1, 1'b0);
      wait_ready("r1", acc + 16);

      send_req(3'd2, 7'd6, 8'h3C);
      expect_cycle("r2_data", acc + 3, 8'h3C, 1'b1, 1'b1, 1'b0);
      wait_ready("r2", acc + 6);

      send_req(3'd2, 7'd70, 8'h11);
      expect_cycle("r3_page", acc + 3,  8'hBA, 1'b0, 1'b0, 1'b1);
      expect_cycle("r3_col",  acc + 8,  8'h46, 1'b0, 1'b0, 1'b1);
      expect_cycle("r3_data", acc + 13, 8'h11, 1'b1, 1'b0, 1'b1);
      wait_ready("r3", acc + 16);

      send_req(3'd2, 7'd7, 8'h22);
      expect_cycle("r4_data", acc + 3, 8'h22, 1'b1, 1'b1, 1'b0);
      wait_ready("r4", acc + 6);

      send_req(3'd0, 7'd63, 8'h55);
      expect_cycle("r5_page", acc + 3,  8'hB8, 1'b0, 1'b1, 1'b0);
      expect_cycle("r5_col",  acc + 8,  8'h7F, 1'b0, 1'b1, 1'b0);
      expect_cycle("r5_data", acc + 13, 8'h55, 1'b1, 1'b1, 1'b0);
      wait_ready("r5", acc + 16);

      send_req(3'd0, 7'd0, 8'h66);
      expect_cycle("r6_wrap", acc + 3, 8'h66, 1'b1, 1'b1, 1'b0);
      wait_ready("r6", acc + 6);

      send_req(3'd0, 7'd63, 8'h77);
      expect_cycle("r7_col",  acc + 3, 8'h7F, 1'b0, 1'b1, 1'b0);
      expect_cycle("r7_data", acc + 8, 8'h77, 1'b1, 1'b1, 1'b0);
      wait_ready("r7", acc + 11);

      send_req(3'd1, 7'd10, 8'h99);
      n = 0;
      while (LCD_en !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("mid_en_seen", 32'(LCD_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_outs",
            32'({LCD_en, LCD_rstn, req_ready, init_done, LCD_cs1, LCD_cs2, LCD_di, LCD_data}),
            32'd0);
      @(negedge clk);
      @(negedge clk);
      check("mid_reset_held", 32'({LCD_en, LCD_rstn, req_ready}), 32'd0);
      run_init("reinit");

      send_req(3'd0, 7'd65, 8'hE1);
      expect_cycle("r8_col",  acc + 3, 8'h41, 1'b0, 1'b0, 1'b1);
      expect_cycle("r8_data", acc + 8, 8'hE1, 1'b1, 1'b0, 1'b1);
      wait_ready("r8", acc + 11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
